// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load access-size encodings and register-file geometry.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned BYTE_SEL_W = 2;

    typedef enum logic [BYTE_SEL_W-1:0] {
        BS_WORD     = 2'b00,
        BS_BYTE     = 2'b01,
        BS_HALF     = 2'b10,
        BS_WORD_ALT = 2'b11
    } byte_sel_e;

endpackage

// File: rtl/load_aligner.sv
// Selects and extends the addressed byte/halfword of a little-endian memory word.
module load_aligner
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]     readWord,
    input  logic [1:0]            addr,
    input  logic [BYTE_SEL_W-1:0] byteSel,
    input  logic                  loadSigned,
    output logic [DATA_W-1:0]     loadData
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal  = readWord[{addr, 3'b000} +: 8];
        halfVal  = readWord[{addr[1], 4'b0000} +: 16];
        loadData = readWord;
        case (byteSel)
            BS_BYTE: loadData = {{(DATA_W-8){loadSigned & byteVal[7]}}, byteVal};
            BS_HALF: loadData = {{(DATA_W-16){loadSigned & halfVal[15]}}, halfVal};
            default: loadData = readWord;
        endcase
    end

endmodule

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: selects the write-back value, registers it with control,
// and counts retired instructions.
module mem_wb_register #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic                            Stall,
    input  logic                            Flush,
    input  logic                            InValid,
    input  logic [DATA_W-1:0]               InPC,
    input  logic [DATA_W-1:0]               InALUResult,
    input  logic [DATA_W-1:0]               InReadData,
    input  logic [mips_pkg::BYTE_SEL_W-1:0] InByteSel,
    input  logic                            InLoadSigned,
    input  logic                            InMemToReg,
    input  logic                            InPCToReg,
    input  logic                            InRegWrite,
    input  logic [REG_ADDR_W-1:0]           InWriteReg,
    output logic                            OutValid,
    output logic [DATA_W-1:0]               OutPC,
    output logic [DATA_W-1:0]               OutWriteData,
    output logic [REG_ADDR_W-1:0]           OutWriteReg,
    output logic                            OutRegWrite,
    output logic [31:0]                     OutRetired
);

    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] writeDataNext;
    logic              regWriteNext;

    load_aligner #(
        .DATA_W(DATA_W)
    ) u_load_aligner (
        .readWord  (InReadData),
        .addr      (InALUResult[1:0]),
        .byteSel   (InByteSel),
        .loadSigned(InLoadSigned),
        .loadData  (loadData)
    );

    // Link-address writes take priority over loads, loads over the ALU result.
    always_comb begin
        writeDataNext = InALUResult;
        if (InPCToReg) begin
            writeDataNext = InPC + DATA_W'(8);
        end else if (InMemToReg) begin
            writeDataNext = loadData;
        end
        regWriteNext = InValid & InRegWrite & (InWriteReg != '0);
    end

    // Flush still loads the datapath fields so the bubble's contents are deterministic.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            OutValid     <= 1'b0;
            OutPC        <= '0;
            OutWriteData <= '0;
            OutWriteReg  <= '0;
            OutRegWrite  <= 1'b0;
            OutRetired   <= '0;
        end else if (Flush) begin
            OutValid     <= 1'b0;
            OutPC        <= InPC;
            OutWriteData <= writeDataNext;
            OutWriteReg  <= InWriteReg;
            OutRegWrite  <= 1'b0;
        end else if (!Stall) begin
            OutValid     <= InValid;
            OutPC        <= InPC;
            OutWriteData <= writeDataNext;
            OutWriteReg  <= InWriteReg;
            OutRegWrite  <= regWriteNext;
            if (InValid) begin
                OutRetired <= OutRetired + 32'd1;
            end
        end
    end

endmodule
